// File: rtl/bd_bridge_pkg.sv
// Shared types and constants for the bundled-data bridges.
package bd_bridge_pkg;

  // The encoding is fixed so that the state can be read directly from a probe.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    REQ   = 2'b10,
    RTZ   = 2'b11
  } state_t;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/bd_sync.sv
// Flop-chain synchroniser for a single asynchronous control bit.
// The transmit bridge uses it for Lack. The receive-side bridge will reuse it.
module bd_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  // Shift the asynchronous input through STAGES flops. Each flop clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/sync_bd_tx_bridge.sv
// Transmit bridge: a synchronous valid/ready producer feeds a small FIFO.
// The FIFO is drained onto a four-phase bundled-data channel (Ldata, Lreq, Lack).
// Optional build macro SYNC_BD_TX_BRIDGE_STATS_EN adds the saturating xfer_cnt output.
module sync_bd_tx_bridge
  import bd_bridge_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     Lreq,
  input  logic                     Lack,
  output logic [DATA_W-1:0]        Ldata,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
`ifdef SYNC_BD_TX_BRIDGE_STATS_EN
  ,
  output logic [15:0]              xfer_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_next;
  state_t            state;
  state_t            state_next;
  logic              lack_s;
  logic              armed;
  logic              push;
  logic              pop;
  logic              load;
  logic              set_req;

  bd_sync #(.STAGES(SYNC_STAGES)) u_lack_sync (
    .clk (clk),
    .rst (rst),
    .d   (Lack),
    .q   (lack_s)
  );

  assign push = in_valid & in_ready;
  assign busy = (state != IDLE) || (fifo_count != '0);

  // Handshake sequencing. The acknowledge counts only once REQ has seen lack_s low.
  // An Lack left high from IDLE or SETUP is therefore ignored.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    set_req    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          load       = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        set_req    = 1'b1;
        state_next = REQ;
      end
      REQ: begin
        if (lack_s && armed) begin
          pop        = 1'b1;
          state_next = RTZ;
        end
      end
      RTZ: begin
        if (!lack_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy after this edge. A push and a pop on the same edge cancel.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CW'(1);
    else if (!push && pop) count_next = fifo_count - CW'(1);
  end

  // Control state, pointers, handshake outputs and the registered in_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      Lreq       <= 1'b0;
      Ldata      <= '0;
      armed      <= 1'b0;
      fifo_count <= '0;
      in_ready   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_next;
      armed      <= (state == REQ) && (armed || !lack_s);
      fifo_count <= count_next;
      in_ready   <= (count_next < CW'(DEPTH));
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (load)    Ldata  <= mem[rd_ptr];
      if (set_req) Lreq   <= 1'b1;
      else if (pop) Lreq  <= 1'b0;
    end
  end

  // FIFO storage. It holds data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef SYNC_BD_TX_BRIDGE_STATS_EN
  // Completed-transfer counter. It holds at SAT_MAX instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (pop && (xfer_cnt != SAT_MAX)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_bd_tx_bridge.sv
// Bench for sync_bd_tx_bridge.
// The scoreboard tracks accepted words in a queue and expects them to appear, in order, at each Lreq rise.
// Occupancy is expected to equal the number of words accepted minus the number of completed handshakes.
module tb_sync_bd_tx_bridge;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              Lreq;
  logic              Lack;
  logic [DATA_W-1:0] Ldata;
  logic [2:0]        fifo_count;
  logic              busy;
`ifdef SYNC_BD_TX_BRIDGE_STATS_EN
  logic [15:0]       xfer_cnt;
`endif

  logic man_lack;
  logic resp_lack;
  logic resp_en;
  int   resp_max;
  assign Lack = man_lack | resp_lack;

  sync_bd_tx_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .Lreq       (Lreq),
    .Lack       (Lack),
    .Ldata      (Ldata),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef SYNC_BD_TX_BRIDGE_STATS_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Four-phase responder: it follows Lreq after a random number of cycles. The edges of Lack fall between clock edges.
  initial begin
    int cnt;
    int dly;
    resp_lack = 1'b0;
    cnt = 0;
    dly = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!resp_en) begin
        resp_lack = 1'b0;
        cnt = 0;
      end else if (Lreq != resp_lack) begin
        if (cnt >= dly) begin
          resp_lack = Lreq;
          cnt = 0;
          dly = $urandom_range(0, resp_max);
        end else begin
          cnt++;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] cur_word;
  int n_in, n_out, n_rise;
  bit mon_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    n_in = 0;
    n_out = 0;
    n_rise = 0;
    cur_word = '0;
  endtask

  task automatic monitor(input logic pp, input logic [DATA_W-1:0] pd, input logic lp);
    int occ;
    if (pp) begin
      exp_q.push_back(pd);
      n_in++;
    end
    if (!lp && Lreq) begin
      n_rise++;
      chk("req_has_word", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) cur_word = exp_q.pop_front();
      chk("ldata_at_req", Ldata, cur_word);
    end else if (lp && Lreq) begin
      chk("ldata_stable", Ldata, cur_word);
    end
    if (lp && !Lreq) n_out++;
    occ = n_in - n_out;
    chk("fifo_count", fifo_count, occ);
    chk("in_ready", in_ready, (occ < DEPTH));
  endtask

  task automatic tick();
    logic pp;
    logic [DATA_W-1:0] pd;
    logic lp;
    pp = in_valid && in_ready;
    pd = in_data;
    lp = Lreq;
    @(posedge clk);
    #1;
    if (mon_en) monitor(pp, pd, lp);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_all_sent", n_in - n_out, 0);
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    man_lack = 1'b0;
    resp_en  = 1'b0;
    tick();
    tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic              exp_rdy;
    logic [2:0]        exp_cnt;
    logic              exp_lreq;
    logic [DATA_W-1:0] exp_ldata;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int n;
    logic [2:0] cnt_before;
    tbl[0] = '{1'b1, 8'h01, 1'b1, 3'd1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h02, 1'b1, 3'd2, 1'b0, 8'h01};
    tbl[2] = '{1'b1, 8'h03, 1'b1, 3'd3, 1'b1, 8'h01};
    tbl[3] = '{1'b1, 8'h04, 1'b0, 3'd4, 1'b1, 8'h01};
    tbl[4] = '{1'b1, 8'h05, 1'b0, 3'd4, 1'b1, 8'h01};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 8'h01};
    resp_max = 1;

    // Reset values, then in_ready rises one edge after release
    do_reset();
    chk("rst_lreq", Lreq, 0);
    chk("rst_ldata", Ldata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready_before_edge", in_ready, 0);
    chk("rst_busy", busy, 0);
    tick();
    chk("ready_after_rst", in_ready, 1);
    mon_en = 1'b1;
    repeat (3) tick();
    chk("idle_lreq", Lreq, 0);
    chk("idle_busy", busy, 0);

    // Fill to full with Lack held low; the fifth word must be refused
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_count", i), fifo_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_lreq", i), Lreq, tbl[i].exp_lreq);
      chk($sformatf("tbl%0d_ldata", i), Ldata, tbl[i].exp_ldata);
    end
    in_valid = 1'b0;
    resp_en = 1'b1;
    wait_drain(200);
    resp_en = 1'b0;
    tick();

    // Single word with a hand-driven Lack
    push_word(8'hA5);
    chk("sw_lreq_e0", Lreq, 0);
    tick();
    chk("sw_ldata_e1", Ldata, 8'hA5);
    chk("sw_lreq_e1", Lreq, 0);
    tick();
    chk("sw_lreq_e2", Lreq, 1);
    repeat (3) tick();
    man_lack = 1'b1;
    n = 0;
    while (Lreq && n < 20) begin tick(); n++; end
    chk("sw_lreq_fall_edges", n, SYNC + 1);
    repeat (3) tick();
    chk("sw_busy_in_rtz", busy, 1);
    man_lack = 1'b0;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("sw_rtz_exit_edges", n, SYNC + 1);
    chk("sw_busy_done", busy, 0);

    // Push lands on the same edge as the pop
    push_word(8'h11);
    n = 0;
    while (!Lreq && n < 10) begin tick(); n++; end
    chk("pp_req_up", Lreq, 1);
    repeat (2) tick();
    man_lack = 1'b1;
    repeat (SYNC) tick();
    cnt_before = fifo_count;
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick();
    in_valid = 1'b0;
    chk("pp_count_same", fifo_count, cnt_before);
    chk("pp_pop_edge", Lreq, 0);
    man_lack = 1'b0;
    repeat (SYNC + 2) tick();
    resp_en = 1'b1;
    wait_drain(100);

    // Randomised traffic against the scoreboard
    resp_max = 3;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_data  = DATA_W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_drain(600);

    // Reset in the middle of a handshake with two words queued behind
    resp_en = 1'b0;
    tick();
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    n = 0;
    while (!Lreq && n < 10) begin tick(); n++; end
    chk("mr_req_up", Lreq, 1);
    chk("mr_count", fifo_count, 3);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mr_lreq_now", Lreq, 0);
    chk("mr_count_now", fifo_count, 0);
    chk("mr_ready_now", in_ready, 0);
    tick();
    tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    tick();
    mon_en = 1'b1;
    resp_en = 1'b1;
    repeat (30) tick();
    chk("mr_no_stale", n_rise, 0);
    chk("mr_idle", busy, 0);
    resp_en = 1'b0;

    // Spurious Lack in IDLE, then Lack held high through IDLE/SETUP
    man_lack = 1'b1;
    repeat (3) tick();
    man_lack = 1'b0;
    repeat (5) tick();
    chk("sp_lreq", Lreq, 0);
    chk("sp_busy", busy, 0);
    chk("sp_count", fifo_count, 0);
    man_lack = 1'b1;
    repeat (4) tick();
    push_word(8'h5A);
    repeat (6) tick();
    chk("hold_lreq", Lreq, 1);
    chk("hold_count", fifo_count, 1);
    man_lack = 1'b0;
    repeat (SYNC + 2) tick();
    resp_en  = 1'b1;
    resp_max = 2;
    push_word(8'h6B);
    push_word(8'h7C);
    wait_drain(200);
    chk("sp_words_sent", n_out, 3);
`ifdef SYNC_BD_TX_BRIDGE_STATS_EN
    chk("sp_xfer_cnt", xfer_cnt, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
